// File: rtl/ysyx_23060077_riscv_mem_load_if.sv
// rtl/ysyx_23060077_riscv_mem_load_if.sv - load request, memory read and write-back bundle for the MEM load unit
interface ysyx_23060077_riscv_mem_load_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5
);
    logic                  load_valid;
    logic                  load_ready;
    logic [DATA_WIDTH-1:0] load_addr;
    logic [2:0]            load_funct3;
    logic [REG_AW-1:0]     load_rd;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [DATA_WIDTH-1:0] mem_req_addr;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    logic                  wb_valid;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [REG_AW-1:0]     wb_rd;
    logic                  load_err;

    // master: EX stage, data memory and write-back around the unit
    modport master (
        output load_valid, load_addr, load_funct3, load_rd,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  load_ready, mem_req_valid, mem_req_addr,
        input  wb_valid, wb_data, wb_rd, load_err
    );

    // slave: the load unit itself
    modport slave (
        input  load_valid, load_addr, load_funct3, load_rd,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output load_ready, mem_req_valid, mem_req_addr,
        output wb_valid, wb_data, wb_rd, load_err
    );
endinterface

// File: rtl/ysyx_23060077_riscv_mem_load.sv
// rtl/ysyx_23060077_riscv_mem_load.sv - MEM-stage load unit: one aligned read, byte/half/word extract, one-cycle write-back
// Optional misaligned-load trap enabled by defining LOAD_MISALIGN_CHECK_EN.
module ysyx_23060077_riscv_mem_load #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_23060077_riscv_mem_load_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state;
    logic [1:0]            off_q;
    logic [2:0]            funct3_q;
    logic [REG_AW-1:0]     rd_q;
    logic [DATA_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] wb_data_q;
    logic [REG_AW-1:0]     wb_rd_q;
    logic                  err_q;

    logic                  misalign;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [DATA_WIDTH-1:0] ext_data;

`ifdef LOAD_MISALIGN_CHECK_EN
    assign misalign = (((bus.load_funct3 == 3'b001) || (bus.load_funct3 == 3'b101)) && bus.load_addr[0])
                    || ((bus.load_funct3 == 3'b010) && (bus.load_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Extraction works on the captured offset so the response word is the only live input.
    always_comb begin
        sel_byte = 8'h00;
        case (off_q)
            2'd0: sel_byte = bus.mem_resp_data[7:0];
            2'd1: sel_byte = bus.mem_resp_data[15:8];
            2'd2: sel_byte = bus.mem_resp_data[23:16];
            2'd3: sel_byte = bus.mem_resp_data[31:24];
            default: sel_byte = 8'h00;
        endcase
        sel_half = off_q[1] ? bus.mem_resp_data[31:16] : bus.mem_resp_data[15:0];

        ext_data = '0;
        case (funct3_q)
            3'b000:  ext_data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
            3'b100:  ext_data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
            3'b001:  ext_data = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
            3'b101:  ext_data = {{(DATA_WIDTH-16){1'b0}}, sel_half};
            3'b010:  ext_data = bus.mem_resp_data;
            default: ext_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            off_q      <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            req_addr_q <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.load_valid) begin
                        off_q      <= bus.load_addr[1:0];
                        funct3_q   <= bus.load_funct3;
                        rd_q       <= bus.load_rd;
                        req_addr_q <= {bus.load_addr[DATA_WIDTH-1:2], 2'b00};
                        if (misalign) begin
                            wb_data_q <= '0;
                            wb_rd_q   <= bus.load_rd;
                            err_q     <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        wb_data_q <= ext_data;
                        wb_rd_q   <= rd_q;
                        err_q     <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.load_ready    = (state == S_IDLE);
    assign bus.mem_req_valid = (state == S_REQ);
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.wb_valid      = (state == S_DONE);
    assign bus.wb_data       = wb_data_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.load_err      = err_q;
endmodule

// File: tb/tb_ysyx_23060077_riscv_mem_load.sv
// tb/tb_ysyx_23060077_riscv_mem_load.sv - directed-vector bench for the MEM load unit
module tb_ysyx_23060077_riscv_mem_load;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    ysyx_23060077_riscv_mem_load_if #(.DATA_WIDTH(32), .REG_AW(5)) bus ();

    ysyx_23060077_riscv_mem_load #(.DATA_WIDTH(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/load_ready"}, 32'(bus.load_ready), 32'd1);
        check({tag, "/req_valid"},  32'(bus.mem_req_valid), 32'd0);
        check({tag, "/req_addr"},   bus.mem_req_addr, 32'd0);
        check({tag, "/wb_valid"},   32'(bus.wb_valid), 32'd0);
        check({tag, "/wb_data"},    bus.wb_data, 32'd0);
        check({tag, "/wb_rd"},      32'(bus.wb_rd), 32'd0);
        check({tag, "/load_err"},   32'(bus.load_err), 32'd0);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [31:0] word,
                            input int rdly, input int sdly, input logic [31:0] exp);
        logic [31:0] ra;
        ra = {addr[31:2], 2'b00};
        check({tag, "/ready"}, 32'(bus.load_ready), 32'd1);
        bus.load_valid  = 1'b1;
        bus.load_addr   = addr;
        bus.load_funct3 = f3;
        bus.load_rd     = rd;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.load_addr  = 32'h0;
        check({tag, "/req_valid"}, 32'(bus.mem_req_valid), 32'd1);
        check({tag, "/req_addr"}, bus.mem_req_addr, ra);
        for (int i = 0; i < rdly; i++) begin
            bus.mem_resp_valid = (i == 1);
            bus.mem_resp_data  = 32'h1111_1111;
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            check({tag, "/stall_req_valid"}, 32'(bus.mem_req_valid), 32'd1);
            check({tag, "/stall_req_addr"}, bus.mem_req_addr, ra);
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        check({tag, "/wait_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        check({tag, "/wait_wb_valid"}, 32'(bus.wb_valid), 32'd0);
        for (int i = 0; i < sdly; i++) begin
            @(negedge clk);
            check({tag, "/resp_wait_wb_valid"}, 32'(bus.wb_valid), 32'd0);
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = word;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
        check({tag, "/wb_valid"}, 32'(bus.wb_valid), 32'd1);
        check({tag, "/wb_data"}, bus.wb_data, exp);
        check({tag, "/wb_rd"}, 32'(bus.wb_rd), 32'(rd));
        check({tag, "/load_err"}, 32'(bus.load_err), 32'd0);
        @(negedge clk);
        check({tag, "/wb_pulse_end"}, 32'(bus.wb_valid), 32'd0);
        check({tag, "/wb_data_hold"}, bus.wb_data, exp);
        check({tag, "/ready_again"}, 32'(bus.load_ready), 32'd1);
    endtask

    initial begin
        bus.load_valid     = 1'b0;
        bus.load_addr      = 32'h0;
        bus.load_funct3    = 3'b000;
        bus.load_rd        = 5'd0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_load("lw",      32'h8000_0004, 3'b010, 5'd5,  32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF);
        run_load("lb_off3", 32'h8000_0003, 3'b000, 5'd6,  32'h8012_3456, 0, 0, 32'hFFFF_FF80);
        run_load("lbu",     32'h8000_0003, 3'b100, 5'd7,  32'h8012_3456, 0, 0, 32'h0000_0080);
        run_load("lb_off1", 32'h8000_0001, 3'b000, 5'd8,  32'h8012_3456, 0, 0, 32'h0000_0034);
        run_load("lh_hi",   32'h8000_0002, 3'b001, 5'd9,  32'h8012_3456, 0, 0, 32'hFFFF_8012);
        run_load("lhu_lo",  32'h8000_0000, 3'b101, 5'd10, 32'h0000_F00D, 0, 0, 32'h0000_F00D);
        run_load("lh_lo",   32'h8000_0000, 3'b001, 5'd11, 32'h1234_F00D, 0, 0, 32'hFFFF_F00D);
        run_load("rsvd",    32'h8000_0008, 3'b011, 5'd12, 32'hFFFF_FFFF, 0, 0, 32'h0000_0000);
        run_load("stall",   32'h1000_0010, 3'b010, 5'd31, 32'hCAFE_F00D, 5, 3, 32'hCAFE_F00D);

        // Reset while waiting for the response: the late response must not produce a write-back.
        bus.load_valid  = 1'b1;
        bus.load_addr   = 32'h2000_0000;
        bus.load_funct3 = 3'b010;
        bus.load_rd     = 5'd3;
        @(negedge clk);
        bus.load_valid    = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h5555_AAAA;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        check("rst_mid/no_wb", 32'(bus.wb_valid), 32'd0);
        check("rst_mid/ready", 32'(bus.load_ready), 32'd1);
        @(negedge clk);
        check("rst_mid/no_wb2", 32'(bus.wb_valid), 32'd0);

`ifdef LOAD_MISALIGN_CHECK_EN
        bus.load_valid  = 1'b1;
        bus.load_addr   = 32'h8000_0002;
        bus.load_funct3 = 3'b010;
        bus.load_rd     = 5'd14;
        @(negedge clk);
        bus.load_valid = 1'b0;
        check("misalign/req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("misalign/wb_valid", 32'(bus.wb_valid), 32'd1);
        check("misalign/load_err", 32'(bus.load_err), 32'd1);
        check("misalign/wb_data", bus.wb_data, 32'd0);
        check("misalign/wb_rd", 32'(bus.wb_rd), 32'd14);
        @(negedge clk);
        check("misalign/wb_end", 32'(bus.wb_valid), 32'd0);
        check("misalign/err_end", 32'(bus.load_err), 32'd0);
        check("misalign/req_valid2", 32'(bus.mem_req_valid), 32'd0);
        run_load("lh_aligned", 32'h8000_0002, 3'b101, 5'd15, 32'hBEEF_0000, 0, 0, 32'h0000_BEEF);
`else
        run_load("lw_lowbits", 32'h8000_0002, 3'b010, 5'd14, 32'h0BAD_C0DE, 0, 0, 32'h0BAD_C0DE);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
